// File: rtl/md_joy_scanner.sv
// md_joy_scanner: drives the DB9 select line through the Mega Drive 6-button sequence and publishes a per-frame button word
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   joyp{1,2,3,4,6,9}_i        DB9 pins, active low, asynchronous
//   joyp7_o                    select line (registered)
//   joy_out[11:0]              {M,X,Y,Z,S,A,C,B,U,D,L,R}, 1 = pressed
//   md_pad, six_btn            pad type seen in the last frame
//   frame_done                 one-cycle pulse when joy_out updates
module md_joy_scanner #(
  parameter logic [15:0] CLK_MHZ = 16'd50,
  parameter int          STEP_US = 10,
  parameter int          IDLE_US = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        joyp1_i,
  input  logic        joyp2_i,
  input  logic        joyp3_i,
  input  logic        joyp4_i,
  input  logic        joyp6_i,
  input  logic        joyp9_i,
  output logic        joyp7_o,
  output logic [11:0] joy_out,
  output logic        md_pad,
  output logic        six_btn,
  output logic        frame_done
);
  localparam int STEP_CYCLES = int'(CLK_MHZ) * STEP_US;
  localparam int IDLE_STEPS  = IDLE_US / STEP_US;
  localparam int PW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
  localparam int IW = IDLE_STEPS > 1 ? $clog2(IDLE_STEPS) : 1;
  typedef enum logic {IDLE, SCAN} state_t;
  state_t      st_q, st_d;
  logic [2:0]  ph_q, ph_d;
  logic [PW-1:0] pre_q;
  logic [IW-1:0] idle_q, idle_d;
  // pin vectors are ordered {pin1,pin2,pin3,pin4,pin6,pin9}
  logic [5:0]  s1_q, s2_q, p0_q;
  logic [3:0]  p1_q, p6_q;
  logic [1:0]  p5_q;
  logic        sel_q, sel_d, done_q, md_q, six_q;
  logic [11:0] joy_q, word;
  logic        tick, idle_end, last, md, six;
  assign tick     = pre_q == PW'(STEP_CYCLES - 1);
  assign idle_end = idle_q == IW'(IDLE_STEPS - 1);
  always_comb begin
    st_d   = st_q;
    ph_d   = ph_q;
    idle_d = idle_q;
    last   = 1'b0;
    if (tick) begin
      if (st_q == IDLE) begin
        idle_d = idle_end ? '0 : idle_q + 1'b1;
        st_d   = idle_end ? SCAN : IDLE;
        ph_d   = '0;
      end else begin
        ph_d = ph_q + 1'b1;
        last = ph_q == 3'd7;
        st_d = last ? IDLE : SCAN;
      end
    end
    sel_d = st_d == IDLE || !ph_d[0];
  end
  // p1_q holds phase-1 {pin3,pin4,pin6,pin9}; p5_q phase-5 {pin1,pin2}; p6_q phase-6 pins 1..4
  assign md   = ~p1_q[3] & ~p1_q[2];
  assign six  = md & ~p5_q[1] & ~p5_q[0];
  assign word = {six & ~p6_q[0], six & ~p6_q[1], six & ~p6_q[2], six & ~p6_q[3],
                 md & ~p1_q[0], md & ~p1_q[1], ~p0_q[0], ~p0_q[1],
                 ~p0_q[5], ~p0_q[4], ~p0_q[3], ~p0_q[2]};
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= IDLE;
      ph_q   <= '0;
      pre_q  <= '0;
      idle_q <= '0;
      sel_q  <= 1'b1;
      s1_q   <= '1;
      s2_q   <= '1;
      p0_q   <= '1;
      p1_q   <= '1;
      p5_q   <= '1;
      p6_q   <= '1;
      joy_q  <= '0;
      md_q   <= 1'b0;
      six_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      ph_q   <= ph_d;
      idle_q <= idle_d;
      sel_q  <= sel_d;
      pre_q  <= tick ? '0 : pre_q + 1'b1;
      s1_q   <= {joyp1_i, joyp2_i, joyp3_i, joyp4_i, joyp6_i, joyp9_i};
      s2_q   <= s1_q;
      done_q <= last;
      if (tick && st_q == SCAN) begin
        if (ph_q == 3'd0) p0_q <= s2_q;
        if (ph_q == 3'd1) p1_q <= s2_q[3:0];
        if (ph_q == 3'd5) p5_q <= s2_q[5:4];
        if (ph_q == 3'd6) p6_q <= s2_q[5:2];
      end
      if (last) begin
        joy_q <= word;
        md_q  <= md;
        six_q <= six;
      end
    end
  end
  assign joyp7_o    = sel_q;
  assign joy_out    = joy_q;
  assign md_pad     = md_q;
  assign six_btn    = six_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_md_joy_scanner.sv
// tb_md_joy_scanner: pad-model driven check of md_joy_scanner with small timing parameters
module tb_md_joy_scanner;
  // STEP_CYCLES = 4, IDLE_STEPS = 10, frame = 72 cycles, first select fall at 44
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  pins;
  logic        joyp7_o, md_pad, six_btn, frame_done;
  logic [11:0] joy_out;
  int          kind = 0;
  logic [11:0] btn = '0;
  int          f = 0;
  int          hi_cnt = 0;
  logic        prev_sel = 1'b1;
  int          vectors = 0;
  int          errs = 0;
  always #5 clk = ~clk;
  md_joy_scanner #(.CLK_MHZ(16'd1), .STEP_US(4), .IDLE_US(40)) dut (
    .clk(clk), .reset(reset),
    .joyp1_i(pins[5]), .joyp2_i(pins[4]), .joyp3_i(pins[3]),
    .joyp4_i(pins[2]), .joyp6_i(pins[1]), .joyp9_i(pins[0]),
    .joyp7_o(joyp7_o), .joy_out(joy_out), .md_pad(md_pad),
    .six_btn(six_btn), .frame_done(frame_done)
  );
  // pad counts select falls; a long select-high period restarts its sequence
  always @(posedge clk) begin
    prev_sel <= joyp7_o;
    hi_cnt   <= joyp7_o ? hi_cnt + 1 : 0;
    if (prev_sel && !joyp7_o) f <= f + 1;
    else if (joyp7_o && hi_cnt >= 12) f <= 0;
  end
  // kind: 0 none, 1 atari, 3 three-button, 6 six-button; b uses joy_out bit order
  function automatic logic [5:0] pad_pins(int k, logic [11:0] b, int fc, logic sel);
    logic [5:0] std_v, low_v;
    std_v = ~{b[3], b[2], b[1], b[0], b[4], b[5]};
    low_v = {~b[3], ~b[2], 2'b00, ~b[6], ~b[7]};
    if (k == 0) return 6'h3F;
    if (k == 1) return std_v;
    if (k == 6 && fc == 3) return sel ? {~b[8], ~b[9], ~b[10], ~b[11], 2'b11} : {4'h0, ~b[6], ~b[7]};
    if (k == 6 && fc == 4 && !sel) return {4'hF, ~b[6], ~b[7]};
    return sel ? std_v : low_v;
  endfunction
  assign pins = pad_pins(kind, btn, f, joyp7_o);
  // {six, md, word}: what a whole frame with a steady pad should report
  function automatic logic [13:0] model(int k, logic [11:0] b);
    case (k)
      1:       return {2'b00, b & 12'h03F};
      3:       return {2'b01, b & 12'h0FF};
      6:       return {2'b11, b};
      default: return '0;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 400);
    chk("frame_done_seen", {31'd0, frame_done}, 1);
  endtask
  task automatic wait_phase(input int fv, input logic sv);
    int n = 0;
    while (!(f == fv && joyp7_o == sv) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("phase_reached", {31'd0, f == fv && joyp7_o == sv}, 1);
  endtask
  task automatic check_frame(input string tag, input int k, input logic [11:0] b);
    int n;
    logic [13:0] e;
    wait_done(n);
    e = model(k, b);
    chk({tag, "_joy"}, {20'd0, joy_out}, {20'd0, e[11:0]});
    chk({tag, "_md"}, {31'd0, md_pad}, {31'd0, e[12]});
    chk({tag, "_six"}, {31'd0, six_btn}, {31'd0, e[13]});
  endtask
  initial begin
    int n, first_fall, trans;
    logic last_sel;
    logic [11:0] b;
    int k;
    repeat (3) @(negedge clk);
    chk("rst_sel", {31'd0, joyp7_o}, 1);
    chk("rst_joy", {20'd0, joy_out}, 0);
    chk("rst_done", {31'd0, frame_done}, 0);
    reset = 1'b0;
    n = 0;
    first_fall = -1;
    trans = 0;
    last_sel = joyp7_o;
    do begin
      @(negedge clk);
      n++;
      if (joyp7_o !== last_sel) begin
        trans++;
        if (first_fall < 0) first_fall = n;
        last_sel = joyp7_o;
      end
    end while (!frame_done && n < 400);
    chk("first_fall", first_fall, 44);
    chk("first_done", n, 72);
    chk("sel_toggles", trans, 8);
    chk("nopad_joy", {20'd0, joy_out}, 0);
    chk("nopad_md", {31'd0, md_pad}, 0);
    wait_done(n);
    chk("frame_period", n, 72);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, frame_done}, 0);
    kind = 1; btn = 12'h018;
    wait_done(n);
    check_frame("atari", 1, 12'h018);
    kind = 3; btn = 12'h048;
    wait_done(n);
    check_frame("three", 3, 12'h048);
    wait_phase(2, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_sel", {31'd0, joyp7_o}, 1);
    chk("mid_rst_joy", {20'd0, joy_out}, 0);
    chk("mid_rst_md", {31'd0, md_pad}, 0);
    chk("mid_rst_six", {31'd0, six_btn}, 0);
    chk("mid_rst_done", {31'd0, frame_done}, 0);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    wait_done(n);
    chk("rst_to_done", n, 72);
    chk("post_rst_joy", {20'd0, joy_out}, 12'h048);
    kind = 6; btn = 12'h480;
    wait_done(n);
    check_frame("six", 6, 12'h480);
    wait_phase(4, 1'b0);
    chk("stable_mid_frame", {20'd0, joy_out}, 12'h480);
    btn = 12'h080;
    wait_done(n);
    chk("x_release_late", {20'd0, joy_out}, 12'h480);
    check_frame("x_released", 6, 12'h080);
    kind = 6; btn = 12'h8C1;
    wait_done(n);
    check_frame("six2", 6, 12'h8C1);
    wait_phase(1, 1'b1);
    kind = 0;
    wait_done(n);
    chk("unplug_joy", {20'd0, joy_out}, 12'h0C1);
    chk("unplug_md", {31'd0, md_pad}, 1);
    chk("unplug_six", {31'd0, six_btn}, 0);
    check_frame("unplugged", 0, 12'h8C1);
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 3))
        0: k = 0;
        1: k = 1;
        2: k = 3;
        default: k = 6;
      endcase
      b = 12'($urandom);
      if (b[3] && b[2]) b[2] = 1'b0;
      if (b[1] && b[0]) b[0] = 1'b0;
      kind = k;
      btn = b;
      wait_done(n);
      check_frame("rand", k, b);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
